// File: rtl/cw_pkg.sv
// Shared definitions for the control-word sequencer: field layout, Psel codes,
// the fetch-cycle control word and the FSM state type.
package cw_pkg;

  localparam int CW_W = 31;

  localparam int PSEL_HI    = 30;
  localparam int PSEL_LO    = 29;
  localparam int DA_HI      = 28;
  localparam int DA_LO      = 24;
  localparam int SA_HI      = 23;
  localparam int SA_LO      = 19;
  localparam int SB_HI      = 18;
  localparam int SB_LO      = 14;
  localparam int FSEL_HI    = 13;
  localparam int FSEL_LO    = 9;
  localparam int REGW_BIT   = 8;
  localparam int RAMW_BIT   = 7;
  localparam int EN_MEM_BIT = 6;
  localparam int EN_ALU_BIT = 5;
  localparam int EN_B_BIT   = 4;
  localparam int EN_PC_BIT  = 3;
  localparam int BSEL_BIT   = 2;
  localparam int PCSEL_BIT  = 1;
  localparam int SL_BIT     = 0;

  localparam logic [1:0] PSEL_HOLD = 2'b00;
  localparam logic [1:0] PSEL_INC  = 2'b01;
  localparam logic [1:0] PSEL_K    = 2'b11;

  // Instruction fetch: memory enabled, PC mux on the incrementer path, PC held.
  localparam logic [CW_W-1:0] FETCH_CW = CW_W'(1) << EN_MEM_BIT;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fsm_t;

endpackage

// File: rtl/cw_sequencer_if.sv
// Bundle between the sequencer, the memory port, the decoder mux and the datapath.
// master = sequencer side, slave = memory/decoder/datapath side.
interface cw_sequencer_if
  import cw_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [CW_W-1:0]   dec_controlword;
    logic [1:0]        dec_nextState;
    logic [63:0]       dec_K;
    logic [31:0]       instruction;
    logic [1:0]        state;
    logic [CW_W-1:0]   controlword;
    logic [63:0]       K;
    logic              ir_load;
    logic              retire;
    logic [CNT_W-1:0]  instr_count;
    logic              wdog_err;

    modport master (
        input  mem_rdata, mem_ready, dec_controlword, dec_nextState, dec_K,
        output instruction, state, controlword, K, ir_load, retire,
               instr_count, wdog_err
    );

    modport slave (
        output mem_rdata, mem_ready, dec_controlword, dec_nextState, dec_K,
        input  instruction, state, controlword, K, ir_load, retire,
               instr_count, wdog_err
    );
endinterface

// File: rtl/cw_gate.sv
// Combinational control-word selection: fetch word in FETCH, decoder word in EXEC,
// with write/shift/PC-update fields suppressed while a memory access is stalled.
module cw_gate
  import cw_pkg::*;
(
    input  logic            in_exec,
    input  logic            fetch_inc,
    input  logic            mem_ready,
    input  logic [CW_W-1:0] dec_cw,
    output logic [CW_W-1:0] cw_out,
    output logic            stall
);

    always_comb begin
        stall  = in_exec && (dec_cw[EN_MEM_BIT] || dec_cw[RAMW_BIT]) && !mem_ready;
        cw_out = FETCH_CW;
        if (!in_exec) begin
            if (fetch_inc) cw_out[PSEL_HI:PSEL_LO] = PSEL_INC;
        end else begin
            cw_out = dec_cw;
            // A stalled cycle must not commit anything; the datapath just waits.
            if (stall) begin
                cw_out[REGW_BIT]        = 1'b0;
                cw_out[RAMW_BIT]        = 1'b0;
                cw_out[SL_BIT]          = 1'b0;
                cw_out[PSEL_HI:PSEL_LO] = PSEL_HOLD;
            end
        end
    end

endmodule

// File: rtl/cw_sequencer.sv
// Fetch/execute sequencer: owns IR, execute state, retire counter and the
// execute-cycle watchdog; feeds the decoders and gates their control word.
module cw_sequencer
  import cw_pkg::*;
#(
    parameter int MAX_EXEC = 4,
    parameter int CNT_W    = 32
)(
    input  logic          clock,
    input  logic          reset_n,
    cw_sequencer_if.master bus
);

    localparam int EC_W = (MAX_EXEC > 1) ? $clog2(MAX_EXEC) : 1;
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(MAX_EXEC - 1);

    fsm_t             fsm_q, fsm_d;
    logic [31:0]      ir_q;
    logic [1:0]       st_q, st_d;
    logic [EC_W-1:0]  ec_q, ec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wdog_q, wdog_d;
    logic             ir_ld, retire_c, stall;
    logic [CW_W-1:0]  cw_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q  <= FETCH;
            ir_q   <= '0;
            st_q   <= 2'b00;
            ec_q   <= '0;
            cnt_q  <= '0;
            wdog_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            ec_q   <= ec_d;
            cnt_q  <= cnt_d;
            wdog_q <= wdog_d;
            if (ir_ld) ir_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        st_d     = st_q;
        ec_d     = ec_q;
        cnt_d    = cnt_q;
        wdog_d   = wdog_q;
        ir_ld    = 1'b0;
        retire_c = 1'b0;
        case (fsm_q)
            FETCH: begin
                // reset_n gate keeps the strobe quiet while reset is held.
                if (bus.mem_ready && reset_n) begin
                    ir_ld = 1'b1;
                    fsm_d = EXEC;
                    st_d  = 2'b00;
                    ec_d  = '0;
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (bus.dec_nextState == 2'b00) begin
                        retire_c = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                        fsm_d    = FETCH;
                        st_d     = 2'b00;
                    end else if (ec_q == EC_LAST) begin
                        // Runaway decoder: abandon the instruction without retiring it.
                        wdog_d = 1'b1;
                        fsm_d  = FETCH;
                        st_d   = 2'b00;
                    end else begin
                        st_d = bus.dec_nextState;
                        ec_d = ec_q + 1'b1;
                    end
                end
            end
            default: fsm_d = FETCH;
        endcase
    end

    cw_gate u_gate (
        .in_exec   (fsm_q == EXEC),
        .fetch_inc (ir_ld),
        .mem_ready (bus.mem_ready),
        .dec_cw    (bus.dec_controlword),
        .cw_out    (cw_c),
        .stall     (stall)
    );

    assign bus.instruction = ir_q;
    assign bus.state       = st_q;
    assign bus.controlword = cw_c;
    assign bus.K           = bus.dec_K;
    assign bus.ir_load     = ir_ld;
    assign bus.retire      = retire_c;
    assign bus.instr_count = cnt_q;
    assign bus.wdog_err    = wdog_q;

endmodule

// File: tb/tb_cw_sequencer.sv
// Randomized bench for cw_sequencer: an instruction-level model queues the
// expected outputs of every cycle, and a negedge monitor pops and compares.
module tb_cw_sequencer;

    localparam int MAX_EXEC = 4;
    localparam logic [30:0] FETCH_CW     = 31'h0000_0040;
    localparam logic [30:0] FETCH_INC_CW = 31'h2000_0040;
    localparam logic [30:0] STALL_CLR    = 31'h6000_0181;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    cw_sequencer_if #(.CNT_W(32)) bus ();

    cw_sequencer #(.MAX_EXEC(MAX_EXEC), .CNT_W(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [30:0] cw;
        logic [63:0] k;
        logic [31:0] ir;
        logic [1:0]  st;
        logic        ild;
        logic        ret;
        logic [31:0] cnt;
        logic        wd;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [31:0] m_ir;
    logic [1:0]  m_st;
    logic [31:0] m_cnt;
    logic        m_wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: sampled mid-cycle, well away from the rising edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("controlword", 64'(bus.controlword), 64'(e.cw));
            chk("K",           bus.K,                e.k);
            chk("instruction", 64'(bus.instruction), 64'(e.ir));
            chk("state",       64'(bus.state),       64'(e.st));
            chk("ir_load",     64'(bus.ir_load),     64'(e.ild));
            chk("retire",      64'(bus.retire),      64'(e.ret));
            chk("instr_count", 64'(bus.instr_count), 64'(e.cnt));
            chk("wdog_err",    64'(bus.wdog_err),    64'(e.wd));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [30:0] cw, input logic [63:0] k,
                        input logic ild, input logic ret);
        exp_q.push_back('{cw, k, m_ir, m_st, ild, ret, m_cnt, m_wd});
    endtask

    task automatic drive(input logic rdy, input logic [31:0] rdata, input logic [30:0] dcw,
                         input logic [1:0] dns, input logic [63:0] dk);
        bus.mem_ready       = rdy;
        bus.mem_rdata       = rdata;
        bus.dec_controlword = dcw;
        bus.dec_nextState   = dns;
        bus.dec_K           = dk;
    endtask

    task automatic model_reset();
        m_ir  = '0;
        m_st  = 2'b00;
        m_cnt = '0;
        m_wd  = 1'b0;
    endtask

    // Cycles spent with reset asserted; decoder inputs are junk and must be ignored.
    task automatic reset_cycles(input int n, input logic rdy);
        logic [63:0] k;
        for (int i = 0; i < n; i++) begin
            k = {$urandom, $urandom};
            drive(rdy, $urandom, 31'($urandom), 2'($urandom), k);
            push(FETCH_CW, k, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic fetch(input logic [31:0] w, input int waits);
        logic [63:0] k;
        for (int i = 0; i < waits; i++) begin
            k = {$urandom, $urandom};
            drive(1'b0, $urandom, 31'($urandom), 2'($urandom), k);
            push(FETCH_CW, k, 1'b0, 1'b0);
            tick();
        end
        k = {$urandom, $urandom};
        drive(1'b1, w, 31'($urandom), 2'($urandom), k);
        push(FETCH_INC_CW, k, 1'b1, 1'b0);
        tick();
        m_ir = w;
        m_st = 2'b00;
    endtask

    // One instruction's execute phase: step i offers cws[i]/nss[i] after stl[i] stalls.
    // The instruction ends on nextState 00 or on its MAX_EXEC-th completing step.
    task automatic exec_instr(input logic [30:0] cws[5], input logic [1:0] nss[5],
                              input int stl[5]);
        logic [63:0] k;
        logic [30:0] cw;
        logic        needs_mem;
        logic        rdy;
        int          done_steps;
        bit          finished;
        done_steps = 0;
        finished   = 0;
        for (int s = 0; s < 5 && !finished; s++) begin
            cw        = cws[s];
            needs_mem = cw[6] | cw[7];
            if (stl[s] > 0 && !needs_mem) begin
                cw[6]     = 1'b1;
                needs_mem = 1'b1;
            end
            for (int j = 0; j < stl[s]; j++) begin
                k = {$urandom, $urandom};
                drive(1'b0, $urandom, cw, nss[s], k);
                push(cw & ~STALL_CLR, k, 1'b0, 1'b0);
                tick();
            end
            k   = {$urandom, $urandom};
            rdy = needs_mem ? 1'b1 : 1'($urandom);
            drive(rdy, $urandom, cw, nss[s], k);
            if (nss[s] == 2'b00) begin
                push(cw, k, 1'b0, 1'b1);
                tick();
                m_cnt    = m_cnt + 1;
                m_st     = 2'b00;
                finished = 1;
            end else if (done_steps == MAX_EXEC - 1) begin
                push(cw, k, 1'b0, 1'b0);
                tick();
                m_wd     = 1'b1;
                m_st     = 2'b00;
                finished = 1;
            end else begin
                push(cw, k, 1'b0, 1'b0);
                tick();
                m_st       = nss[s];
                done_steps = done_steps + 1;
            end
        end
    endtask

    initial begin
        logic [30:0] cws[5];
        logic [1:0]  nss[5];
        int          stl[5];
        logic [63:0] k;

        reset_n = 1'b0;
        drive(1'b1, 32'h1400_0003, '0, 2'b00, '0);
        model_reset();
        tick();
        reset_cycles(2, 1'b1);
        reset_n = 1'b1;

        // Branch-like single-state instruction straight out of reset.
        fetch(32'h1400_0003, 0);
        cws = '{31'h6000_0002, 31'h0, 31'h0, 31'h0, 31'h0};
        nss = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        stl = '{0, 0, 0, 0, 0};
        exec_instr(cws, nss, stl);

        // Slow instruction memory.
        fetch(32'h8B02_0020, 3);
        cws = '{31'h0A0C_4123, 31'h0, 31'h0, 31'h0, 31'h0};
        exec_instr(cws, nss, stl);

        // Store stalled for two cycles.
        fetch(32'hF800_0041, 0);
        cws = '{31'h6000_01C3, 31'h0, 31'h0, 31'h0, 31'h0};
        stl = '{2, 0, 0, 0, 0};
        exec_instr(cws, nss, stl);

        // Three-state instruction.
        fetch(32'hF840_0062, 1);
        cws = '{31'h0000_0041, 31'h0108_0120, 31'h4000_0109, 31'h0, 31'h0};
        nss = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        stl = '{0, 1, 0, 0, 0};
        exec_instr(cws, nss, stl);

        // Decoder stuck on nextState 01: watchdog abort.
        fetch(32'hDEAD_BEEF, 0);
        cws = '{31'h0000_0100, 31'h0000_0100, 31'h0000_0100, 31'h0000_0100, 31'h0000_0100};
        nss = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        stl = '{0, 0, 0, 0, 0};
        exec_instr(cws, nss, stl);

        // Healthy instruction afterwards: error flag stays set.
        fetch(32'h1400_0010, 0);
        cws = '{31'h6000_0002, 31'h0, 31'h0, 31'h0, 31'h0};
        nss = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        exec_instr(cws, nss, stl);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            for (int s = 0; s < 5; s++) begin
                cws[s] = 31'($urandom);
                nss[s] = 2'($urandom_range(0, 3));
                stl[s] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            fetch($urandom, int'($urandom_range(0, 2)));
            exec_instr(cws, nss, stl);
        end

        // Reset asserted in the middle of a stalled store.
        fetch(32'hF800_0099, 0);
        k = {$urandom, $urandom};
        drive(1'b0, $urandom, 31'h0000_01C1, 2'b00, k);
        push(31'h0000_0040, k, 1'b0, 1'b0);
        tick();
        reset_n = 1'b0;
        model_reset();
        push(FETCH_CW, k, 1'b0, 1'b0);
        tick();
        reset_cycles(1, 1'b1);
        reset_n = 1'b1;

        fetch(32'h1400_0003, 0);
        cws = '{31'h6000_0002, 31'h0, 31'h0, 31'h0, 31'h0};
        nss = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        stl = '{0, 0, 0, 0, 0};
        exec_instr(cws, nss, stl);

        @(negedge clock);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete, %0d checks pending", exp_q.size());
        $fatal(1, "timeout");
    end

endmodule
